adc_readout_arbiter: RTL and testbench

Downstream consumer of the eight ADC deserializer channels in the ADC frontend. Each channel holds a FIFO of sample sets, where one set is four 10-bit samples (a, b, c, d). This block arbitrates round-robin across the non-empty, enabled channels and pops one set at a time. It packs each set into two tagged 32-bit words and presents them on a valid/ready stream for the DAQ readout path.

---
 rtl/adc_readout_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_adc_readout_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_arbiter.sv
// Round-robin readout of the eight ADC deserializer FIFOs. Each popped set of
// four samples is emitted as two tagged 32-bit words on a valid/ready stream.
module adc_readout_arbiter #(
    parameter int NCHAN    = 8,
    parameter int SAMPLE_W = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NCHAN-1:0]          chan_mask,
    input  logic [NCHAN-1:0]          buffer_empty,
    output logic [NCHAN-1:0]          buffer_rdreq,
    input  logic [NCHAN*SAMPLE_W-1:0] buffer_data_a,
    input  logic [NCHAN*SAMPLE_W-1:0] buffer_data_b,
    input  logic [NCHAN*SAMPLE_W-1:0] buffer_data_c,
    input  logic [NCHAN*SAMPLE_W-1:0] buffer_data_d,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [15:0]               sets_read
);

    localparam int CHAN_W = 3;
    localparam int SEQ_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WORD0   = 3'd3,
        ST_WORD1   = 3'd4
    } state_t;

    function automatic logic [31:0] pack_word(
        input logic [1:0]          tag,
        input logic [CHAN_W-1:0]   chan,
        input logic [SEQ_W-1:0]    seq,
        input logic [SAMPLE_W-1:0] hi,
        input logic [SAMPLE_W-1:0] lo
    );
        return {tag, chan, seq, hi, lo};
    endfunction

    logic                rst_meta_r;
    logic                rst_sync_r;

    state_t              state_r;
    state_t              state_s;

    logic [SAMPLE_W-1:0] samp_a_s [NCHAN];
    logic [SAMPLE_W-1:0] samp_b_s [NCHAN];
    logic [SAMPLE_W-1:0] samp_c_s [NCHAN];
    logic [SAMPLE_W-1:0] samp_d_s [NCHAN];

    logic [NCHAN-1:0]    elig_s;
    logic                hit_s;
    logic [CHAN_W-1:0]   pick_s;
    logic [CHAN_W-1:0]   cand_s;

    logic [CHAN_W-1:0]   sel_chan_r;
    logic [CHAN_W-1:0]   sel_chan_s;
    logic [CHAN_W-1:0]   last_chan_r;
    logic [CHAN_W-1:0]   last_chan_s;
    logic [SAMPLE_W-1:0] samp_c_r;
    logic [SAMPLE_W-1:0] samp_c_nxt_s;
    logic [SAMPLE_W-1:0] samp_d_r;
    logic [SAMPLE_W-1:0] samp_d_nxt_s;
    logic [SEQ_W-1:0]    seq_r [NCHAN];
    logic [SEQ_W-1:0]    cur_seq_s;

    logic [NCHAN-1:0]    rdreq_r;
    logic [NCHAN-1:0]    rdreq_s;
    logic [31:0]         out_data_r;
    logic [31:0]         out_data_s;
    logic                out_valid_r;
    logic                out_valid_s;
    logic                busy_r;
    logic                busy_s;
    logic [15:0]         sets_read_r;
    logic                commit_s;

    // Reset synchronizer: assertion is immediate, release follows two clock edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Split the flat per-channel sample buses into indexable arrays
    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            samp_a_s[i] = buffer_data_a[i*SAMPLE_W +: SAMPLE_W];
            samp_b_s[i] = buffer_data_b[i*SAMPLE_W +: SAMPLE_W];
            samp_c_s[i] = buffer_data_c[i*SAMPLE_W +: SAMPLE_W];
            samp_d_s[i] = buffer_data_d[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Round-robin search starting just after the last serviced channel
    always_comb begin
        elig_s = enable ? (chan_mask & ~buffer_empty) : {NCHAN{1'b0}};
        hit_s  = 1'b0;
        pick_s = {CHAN_W{1'b0}};
        cand_s = {CHAN_W{1'b0}};
        for (int k = 1; k <= NCHAN; k++) begin
            cand_s = last_chan_r + CHAN_W'(k);
            if (!hit_s && elig_s[cand_s]) begin
                hit_s  = 1'b1;
                pick_s = cand_s;
            end else begin
                hit_s  = hit_s;
            end
        end
    end

    assign cur_seq_s = seq_r[sel_chan_r];

    // Next-state and next-output logic for the readout FSM
    always_comb begin
        state_s      = state_r;
        sel_chan_s   = sel_chan_r;
        last_chan_s  = last_chan_r;
        samp_c_nxt_s = samp_c_r;
        samp_d_nxt_s = samp_d_r;
        rdreq_s      = {NCHAN{1'b0}};
        out_data_s   = out_data_r;
        out_valid_s  = out_valid_r;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    sel_chan_s = pick_s;
                    rdreq_s    = {{(NCHAN-1){1'b0}}, 1'b1} << pick_s;
                    state_s    = ST_READ;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_CAPTURE;
            end
            // FIFO output is valid this cycle; word 0 is built straight from it
            ST_CAPTURE: begin
                samp_c_nxt_s = samp_c_s[sel_chan_r];
                samp_d_nxt_s = samp_d_s[sel_chan_r];
                out_data_s   = pack_word(2'b10, sel_chan_r, cur_seq_s,
                                         samp_a_s[sel_chan_r], samp_b_s[sel_chan_r]);
                out_valid_s  = 1'b1;
                state_s      = ST_WORD0;
            end
            ST_WORD0: begin
                if (out_ready) begin
                    out_data_s = pack_word(2'b01, sel_chan_r, cur_seq_s,
                                           samp_c_r, samp_d_r);
                    state_s    = ST_WORD1;
                end else begin
                    state_s    = ST_WORD0;
                end
            end
            ST_WORD1: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    commit_s    = 1'b1;
                    last_chan_s = sel_chan_r;
                    state_s     = ST_IDLE;
                end else begin
                    state_s     = ST_WORD1;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Channel bookkeeping, latched samples and registered outputs
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            sel_chan_r  <= {CHAN_W{1'b0}};
            last_chan_r <= 3'd7;
            samp_c_r    <= {SAMPLE_W{1'b0}};
            samp_d_r    <= {SAMPLE_W{1'b0}};
            rdreq_r     <= {NCHAN{1'b0}};
            out_data_r  <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            sets_read_r <= 16'h0000;
        end else begin
            sel_chan_r  <= sel_chan_s;
            last_chan_r <= last_chan_s;
            samp_c_r    <= samp_c_nxt_s;
            samp_d_r    <= samp_d_nxt_s;
            rdreq_r     <= rdreq_s;
            out_data_r  <= out_data_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            sets_read_r <= commit_s ? (sets_read_r + 16'd1) : sets_read_r;
        end
    end

    // Per-channel sequence counters, advanced once both words are accepted
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            for (int i = 0; i < NCHAN; i++) begin
                seq_r[i] <= {SEQ_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (commit_s && (sel_chan_r == CHAN_W'(i))) begin
                    seq_r[i] <= seq_r[i] + 7'd1;
                end else begin
                    seq_r[i] <= seq_r[i];
                end
            end
        end
    end

    assign buffer_rdreq = rdreq_r;
    assign out_data     = out_data_r;
    assign out_valid    = out_valid_r;
    assign busy         = busy_r;
    assign sets_read    = sets_read_r;

endmodule

// File: tb/tb_adc_readout_arbiter.sv
// Scoreboard bench for adc_readout_arbiter: a FIFO model feeds the channels,
// expected words are queued at stimulus time and a monitor pops on each accept.
module tb_adc_readout_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  chan_mask;
    logic [7:0]  buffer_empty;
    logic [7:0]  buffer_rdreq;
    logic [79:0] buffer_data_a;
    logic [79:0] buffer_data_b;
    logic [79:0] buffer_data_c;
    logic [79:0] buffer_data_d;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] sets_read;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt [8];
    logic [7:0]  prev_rdreq = 8'h00;
    logic [39:0] fifo_q [8][$];
    logic [31:0] exp_q [$];
    logic [6:0]  exp_seq [8];

    adc_readout_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .chan_mask     (chan_mask),
        .buffer_empty  (buffer_empty),
        .buffer_rdreq  (buffer_rdreq),
        .buffer_data_a (buffer_data_a),
        .buffer_data_b (buffer_data_b),
        .buffer_data_c (buffer_data_c),
        .buffer_data_d (buffer_data_d),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .sets_read     (sets_read)
    );

    always #5 clk = ~clk;

    // Normal-mode FIFO model: data appears the cycle after the read request
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 8; i++) begin
            if (buffer_rdreq[i] && fifo_q[i].size() > 0) begin
                buffer_data_a[i*10 +: 10] <= fifo_q[i][0][39:30];
                buffer_data_b[i*10 +: 10] <= fifo_q[i][0][29:20];
                buffer_data_c[i*10 +: 10] <= fifo_q[i][0][19:10];
                buffer_data_d[i*10 +: 10] <= fifo_q[i][0][9:0];
                fifo_q[i].delete(0);
            end
        end
    end

    // Empty flags follow the model FIFO occupancy
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) begin
            buffer_empty[i] <= (fifo_q[i].size() == 0);
        end
    end

    // Monitor: rdreq legality and scoreboard compare on every accepted word
    always @(negedge clk) begin
        if (reset) begin
            if (buffer_rdreq != 8'h00) begin
                checks++;
                if ($countones(buffer_rdreq) != 1 || (prev_rdreq & buffer_rdreq) != 8'h00 || out_valid) begin
                    errors++;
                    $display("FAIL rdreq_pulse actual=%b prev=%b valid=%b required=single one-cycle bit",
                             buffer_rdreq, prev_rdreq, out_valid);
                end
                for (int i = 0; i < 8; i++) begin
                    if (buffer_rdreq[i]) rd_cnt[i]++;
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL stream_word actual=%h required=%h", out_data, exp_q[0]);
                    end
                    exp_q.delete(0);
                end
            end
        end
        prev_rdreq = buffer_rdreq;
    end

    function automatic logic [31:0] mkw(input logic [1:0] tag, input int ch, input logic [6:0] s,
                                        input logic [9:0] x, input logic [9:0] y);
        return {tag, 3'(ch), s, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic load(input int ch, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] c, input logic [9:0] d);
        fifo_q[ch].push_back({a, b, c, d});
    endtask

    task automatic expect_set(input int ch, input logic [9:0] a, input logic [9:0] b,
                              input logic [9:0] c, input logic [9:0] d);
        exp_q.push_back(mkw(2'b10, ch, exp_seq[ch], a, b));
        exp_q.push_back(mkw(2'b01, ch, exp_seq[ch], c, d));
        exp_seq[ch] = exp_seq[ch] + 7'd1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t_rd;
        int          t_w0;
        int          t_w1;
        int          pulses;
        int          snap0;
        int          snap2;
        logic [15:0] base;
        logic [31:0] w0;

        for (int i = 0; i < 8; i++) begin
            rd_cnt[i]  = 0;
            exp_seq[i] = 7'd0;
        end
        reset     = 1'b0;
        enable    = 1'b0;
        chan_mask = 8'h00;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rdreq", 32'(buffer_rdreq), 32'd0);
        chk("reset_data", out_data, 32'h0);
        chk("reset_sets", 32'(sets_read), 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // Single set on channel 0, latency and exact words
        enable    = 1'b1;
        chan_mask = 8'hFF;
        out_ready = 1'b1;
        load(0, 10'h001, 10'h002, 10'h003, 10'h004);
        exp_q.push_back(32'h8000_0402);
        exp_q.push_back(32'h4000_0C04);
        exp_seq[0] = 7'd1;
        t_rd = -1; t_w0 = -1; t_w1 = -1; pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (buffer_rdreq[0]) begin
                pulses++;
                if (t_rd < 0) t_rd = cyc;
            end
            if (out_valid && out_data == 32'h8000_0402 && t_w0 < 0) t_w0 = cyc;
            if (out_valid && out_data == 32'h4000_0C04 && t_w1 < 0) t_w1 = cyc;
        end
        chk("t1_rdreq_pulses", 32'(pulses), 32'd1);
        chk("t1_word0_lat", 32'(t_w0 - t_rd), 32'd2);
        chk("t1_word1_lat", 32'(t_w1 - t_w0), 32'd1);
        wait_drain("t1_drain", 50);
        chk("t1_sets", 32'(sets_read), 32'd1);

        // Channels 2, 5, 7 loaded together: served in that order
        tick();
        load(2, 10'h3FF, 10'h000, 10'h155, 10'h2AA);
        load(5, 10'h123, 10'h045, 10'h067, 10'h089);
        load(7, 10'h200, 10'h100, 10'h080, 10'h040);
        expect_set(2, 10'h3FF, 10'h000, 10'h155, 10'h2AA);
        expect_set(5, 10'h123, 10'h045, 10'h067, 10'h089);
        expect_set(7, 10'h200, 10'h100, 10'h080, 10'h040);
        wait_drain("t2_drain", 100);
        chk("t2_sets", 32'(sets_read), 32'd4);

        // Mask 0x0A over channels 0..3 with three sets each
        tick();
        chan_mask = 8'h0A;
        snap0 = rd_cnt[0];
        snap2 = rd_cnt[2];
        for (int s = 0; s < 3; s++) begin
            for (int ch = 0; ch < 4; ch++) begin
                load(ch, 10'(16*ch + 4*s), 10'(16*ch + 4*s + 1), 10'(16*ch + 4*s + 2), 10'(16*ch + 4*s + 3));
            end
        end
        for (int s = 0; s < 3; s++) begin
            expect_set(1, 10'(16 + 4*s), 10'(17 + 4*s), 10'(18 + 4*s), 10'(19 + 4*s));
            expect_set(3, 10'(48 + 4*s), 10'(49 + 4*s), 10'(50 + 4*s), 10'(51 + 4*s));
        end
        wait_drain("t3_drain", 200);
        chk("t3_sets", 32'(sets_read), 32'd10);
        chk("t3_ch0_untouched", 32'(rd_cnt[0] - snap0), 32'd0);
        chk("t3_ch2_untouched", 32'(rd_cnt[2] - snap2), 32'd0);

        // Data pending only on masked channels, then enable low: must stay idle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("idle_masked_busy", 32'(busy), 32'd0);
        end
        tick();
        enable    = 1'b0;
        chan_mask = 8'hFF;
        repeat (6) @(negedge clk);
        chk("idle_disabled_busy", 32'(busy), 32'd0);
        chk("idle_disabled_rdreq", 32'(buffer_rdreq), 32'd0);

        // Backpressure during WORD0 on channel 5
        tick();
        enable    = 1'b1;
        chan_mask = 8'h20;
        out_ready = 1'b0;
        load(5, 10'h311, 10'h022, 10'h033, 10'h044);
        w0 = mkw(2'b10, 5, exp_seq[5], 10'h311, 10'h022);
        expect_set(5, 10'h311, 10'h022, 10'h033, 10'h044);
        wait_valid("t4_wait_valid", 30);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_stall_valid", 32'(out_valid), 32'd1);
            chk("t4_stall_data", out_data, w0);
            chk("t4_stall_rdreq", 32'(buffer_rdreq), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_resume_word1", out_data, mkw(2'b01, 5, 7'd1, 10'h033, 10'h044));
        chk("t4_resume_valid", 32'(out_valid), 32'd1);
        wait_drain("t4_drain", 50);
        chk("t4_sets", 32'(sets_read), 32'd11);

        // 130 sets on channel 4: sequence field wraps 127 -> 0
        tick();
        chan_mask = 8'h10;
        base = sets_read;
        for (int k = 0; k < 130; k++) begin
            load(4, 10'(k), 10'(k) ^ 10'h3FF, 10'(2*k), 10'(k + 500));
            expect_set(4, 10'(k), 10'(k) ^ 10'h3FF, 10'(2*k), 10'(k + 500));
        end
        wait_drain("t5_drain", 1000);
        chk("t5_sets_delta", 32'(sets_read - base), 32'd130);
        chk("t5_seq_after_wrap", 32'(exp_seq[4]), 32'd2);

        // Reset while holding in WORD1
        tick();
        out_ready = 1'b0;
        load(4, 10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD);
        exp_q.push_back(mkw(2'b10, 4, 7'd2, 10'h0AA, 10'h0BB));
        wait_valid("t6_wait_valid", 30);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t6_in_word1_valid", 32'(out_valid), 32'd1);
        chk("t6_in_word1_tag", 32'(out_data[31:30]), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_sets", 32'(sets_read), 32'd0);
        chk("t6_rst_rdreq", 32'(buffer_rdreq), 32'd0);
        for (int i = 0; i < 8; i++) exp_seq[i] = 7'd0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        out_ready = 1'b1;
        load(4, 10'h1E1, 10'h2D2, 10'h3C3, 10'h0B4);
        expect_set(4, 10'h1E1, 10'h2D2, 10'h3C3, 10'h0B4);
        wait_drain("t6_drain", 50);
        chk("t6_sets_after", 32'(sets_read), 32'd1);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
